e_mdu: RTL and testbench

Parametrised multi-cycle multiply/divide unit in the E stage, next to the ALU, holding architectural HI/LO registers. Operations start on a one-cycle start pulse. The unit stays busy for a configurable number of cycles, then commits results to HI/LO. The hazard unit stalls any D-stage multiply/divide-class instruction while `start` or `busy` is high.

---
 rtl/e_mdu.sv | 160 ++++++++++++++++
 tb/tb_e_mdu.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// e_mdu -- multi-cycle multiply/divide unit for the E stage.
//
// Holds the architectural HI/LO registers. A one-cycle start pulse with
// op 0..3 latches the operands and keeps the unit busy for MULT_CYCLES or
// DIV_CYCLES cycles before the result is committed to {hi,lo}. MTHI/MTLO
// (op 4/5) write hi/lo directly at the start edge. A start while busy is
// ignored.
//
// Optional feature: define MDU_CANCEL_EN to add the cancel input, which
// aborts an operation in flight (no commit) or suppresses a coincident start.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   start  in   one-cycle request; op/a/b sampled on this edge
//   op     in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved
//   a, b   in   rs / rt operands
//   cancel in   flush request (MDU_CANCEL_EN only)
//   busy   out  multiply/divide in flight
//   done   out  one-cycle pulse in the cycle the result commits
//   hi, lo out  HI / LO registers
module e_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MDU_CANCEL_EN
    input  logic             cancel,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [1:0]         op_q, op_d;     // only ops 0..3 ever enter RUN
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;
    logic               cancel_w;

`ifdef MDU_CANCEL_EN
    assign cancel_w = cancel;
`else
    assign cancel_w = 1'b0;
`endif

    // Result from the latched operands; op_q[0] selects unsigned, op_q[1] divide.
    logic [2*WIDTH-1:0] ext_a, ext_b, prod, res;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        ext_a = op_q[0] ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{a_q[WIDTH-1]}}, a_q};
        ext_b = op_q[0] ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{b_q[WIDTH-1]}}, b_q};
        prod  = ext_a * ext_b;   // low 2*WIDTH bits are the exact signed/unsigned product
        quo   = '0;
        rem   = '0;
        if (b_q == '0) begin
            quo = '1;
            rem = a_q;
        end else if (!op_q[0]) begin
            // Most-negative / -1 would overflow the quotient; pin it explicitly.
            if (a_q == MOST_NEG && b_q == '1) begin
                quo = a_q;
                rem = '0;
            end else begin
                quo = $signed(a_q) / $signed(b_q);
                rem = $signed(a_q) % $signed(b_q);
            end
        end else begin
            quo = a_q / b_q;
            rem = a_q % b_q;
        end
        res = op_q[1] ? {rem, quo} : prod;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !cancel_w) begin
                    case (op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            a_d     = a;
                            b_d     = b;
                            op_d    = op[1:0];
                            cnt_d   = op[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
                            state_d = S_RUN;
                        end
                        3'd4:    hi_d = a;
                        3'd5:    lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (cancel_w) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    hi_d    = res[2*WIDTH-1:WIDTH];
                    lo_d    = res[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Testbench for e_mdu (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10).
// Randomized and directed operations checked against a plain-arithmetic
// reference model of HI/LO. Define MDU_CANCEL_EN to also exercise cancel.
module tb_e_mdu;

    localparam int W  = 32;
    localparam int NM = 5;
    localparam int ND = 10;

    logic         clk;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
`ifdef MDU_CANCEL_EN
    logic         cancel;
`endif
    logic         busy, done;
    logic [W-1:0] hi, lo;

    e_mdu #(.WIDTH(W), .MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
`ifdef MDU_CANCEL_EN
        .cancel (cancel),
`endif
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {hi,lo} for ops 0..3 from ordinary integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy;
        longint unsigned ux, uy;
        int              ix, iy;
        case (o)
            3'd0: begin
                ix = x; iy = y;
                sx = ix; sy = iy;
                return 64'(sx * sy);
            end
            3'd1: begin
                ux = x; uy = y;
                return 64'(ux * uy);
            end
            3'd2: begin
                ix = x; iy = y;
                if (iy == 0) return {x, 32'hFFFF_FFFF};
                if (ix == 32'sh8000_0000 && iy == -1) return {32'h0, x};
                return {32'(ix % iy), 32'(ix / iy)};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a multiply/divide and follow it to commit. With intrude set,
    // a DIVU and an MTLO are pulsed while busy; both must be ignored.
    task automatic run_mdu(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit intrude);
        int          n;
        logic [63:0] r;
        n = o[1] ? ND : NM;
        r = model(o, x, y);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
        check("busy_at_start", busy, 1);
        check("done_at_start", done, 0);
        for (int i = 1; i < n; i++) begin
            if (intrude && i == 1) begin
                start = 1'b1; op = 3'd3; a = $urandom; b = 32'd0;
                $display("hazard: DIVU start while busy (must be ignored)");
            end
            if (intrude && i == 2) begin
                start = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF;
                $display("hazard: MTLO start while busy (must be ignored)");
            end
            tick();
            start = 1'b0;
            check("busy_run", busy, 1);
            check("done_run", done, 0);
            check("hi_hold", hi, exp_hi);
            check("lo_hold", lo, exp_lo);
        end
        tick();
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        check("busy_commit", busy, 0);
        check("done_commit", done, 1);
        check("hi_commit", hi, exp_hi);
        check("lo_commit", lo, exp_lo);
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h (expect %h %h)", o, x, y, hi, lo, exp_hi, exp_lo);
    endtask

    // MTHI / MTLO / reserved: effect at the start edge, never busy/done.
    task automatic run_mt(input logic [2:0] o, input logic [31:0] x);
        op = o; a = x; start = 1'b1;
        tick();
        start = 1'b0; a = $urandom;
        if (o == 3'd4) exp_hi = x;
        if (o == 3'd5) exp_lo = x;
        check("mt_busy", busy, 0);
        check("mt_done", done, 0);
        check("mt_hi", hi, exp_hi);
        check("mt_lo", lo, exp_lo);
        $display("op=%0d a=%h -> hi=%h lo=%h (expect %h %h)", o, x, hi, lo, exp_hi, exp_lo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

`ifdef MDU_CANCEL_EN
    // Start a DIV and cancel it at edge k+at (at==ND is the commit edge).
    task automatic run_cancel(input int at);
        run_mt(3'd4, 32'h1111_1111);
        run_mt(3'd5, 32'h1111_1111);
        op = 3'd2; a = 32'd100; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < at; i++) tick();
        check("cancel_busy_before", busy, 1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_busy", busy, 0);
        for (int i = 0; i < 12; i++) begin
            check("cancel_done", done, 0);
            tick();
        end
        check("cancel_hi", hi, 32'h1111_1111);
        check("cancel_lo", lo, 32'h1111_1111);
        $display("cancel at cycle %0d -> hi=%h lo=%h busy=%0d", at, hi, lo, busy);
    endtask
`endif

    initial begin
        start = 1'b0; op = '0; a = '0; b = '0;
`ifdef MDU_CANCEL_EN
        cancel = 1'b0;
`endif
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        $display("reset released: busy=%0d done=%0d hi=%h lo=%h", busy, done, hi, lo);

        // MULT / MULTU
        run_mdu(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("mult_hi_const", hi, 32'hFFFF_FFFF);
        check("mult_lo_const", lo, 32'hFFFF_FFFA);
        run_mdu(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("multu_hi_const", hi, 32'h0000_0002);
        check("multu_lo_const", lo, 32'hFFFF_FFFA);

        // DIV / DIVU boundaries
        run_mdu(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_lo_const", lo, 32'hFFFF_FFFD);
        check("div_hi_const", hi, 32'hFFFF_FFFF);
        run_mdu(3'd3, 32'd7, 32'd0, 1'b0);
        check("divu0_lo_const", lo, 32'hFFFF_FFFF);
        check("divu0_hi_const", hi, 32'd7);
        run_mdu(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("divovf_lo_const", lo, 32'h8000_0000);
        check("divovf_hi_const", hi, 32'h0);
        run_mdu(3'd2, 32'd5, 32'd0, 1'b0);

        // MTHI then MTLO on consecutive cycles
        run_mt(3'd4, 32'h1234_5678);
        run_mt(3'd5, 32'h9ABC_DEF0);
        check("mthi_const", hi, 32'h1234_5678);
        check("mtlo_const", lo, 32'h9ABC_DEF0);
        run_mt(3'd6, 32'hCAFE_F00D);

        // Starts while busy are ignored; back-to-back MULT after done
        run_mdu(3'd0, 32'd1000, 32'hFFFF_FFF0, 1'b1);
        run_mdu(3'd0, 32'h0001_0000, 32'h0001_0000, 1'b0);
        check("b2b_hi_const", hi, 32'h1);
        check("b2b_lo_const", lo, 32'h0);

        // Randomized mix
        for (int t = 0; t < 40; t++) begin
            logic [2:0]  o;
            logic [31:0] x, y;
            o = 3'($urandom_range(0, 7));
            x = pick();
            y = pick();
            if (o <= 3'd3) run_mdu(o, x, y, 1'b0);
            else           run_mt(o, x);
            if ($urandom_range(0, 3) == 0) begin
                tick();
                check("idle_busy", busy, 0);
                check("idle_done", done, 0);
            end
        end

        // Reset mid-DIV: immediate clear, no commit afterwards
        run_mt(3'd4, 32'hA5A5_A5A5);
        run_mt(3'd5, 32'h5A5A_5A5A);
        op = 3'd2; a = 32'd1000; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #2 reset = 1'b0;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        check("midrst_busy", busy, 0);
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("postrst_done", done, 0);
            check("postrst_busy", busy, 0);
        end
        check("postrst_hi", hi, 0);
        check("postrst_lo", lo, 0);
        $display("reset mid-DIV: hi=%h lo=%h busy=%0d", hi, lo, busy);

`ifdef MDU_CANCEL_EN
        run_cancel(4);
        run_cancel(ND);
        exp_hi = 32'h1111_1111;
        exp_lo = 32'h1111_1111;
        cancel = 1'b1; op = 3'd4; a = 32'h2222_2222; start = 1'b1;
        tick();
        cancel = 1'b0; start = 1'b0;
        check("cancel_mthi_hi", hi, 32'h1111_1111);
        check("cancel_mthi_busy", busy, 0);
        cancel = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3; start = 1'b1;
        tick();
        cancel = 1'b0; start = 1'b0;
        check("cancel_start_busy", busy, 0);
        $display("cancel with start: hi=%h lo=%h busy=%0d", hi, lo, busy);
        run_mdu(3'd1, 32'd6, 32'd7, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
